flash_rom_loader: RTL and testbench

Boot-time copy sequencer that transfers the MEGAROM and BIOS (Nextor + FM) images from serial flash into their shadow regions of external RAM after reset. It sits between the flash reader and the RAM arbiter, and owns both ports until the copy completes. The cartridge core holds the MSX bus in wait/hi-Z while BUSY is high. The copy moves 16-bit words and runs up to two jobs in a fixed order.

---
 rtl/flash_rom_loader_if.sv | 26 ++
 rtl/flash_rom_loader.sv | 183 ++++++++++++++++++
 tb/tb_flash_rom_loader.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_rom_loader_if.sv
// Handshake bundle between the boot copier, the serial flash reader and the RAM arbiter.
// The master side is the copier; the slave side is the flash/RAM pair it drives.
interface flash_rom_loader_if;
    logic        flash_req;
    logic [23:0] flash_addr;
    logic        flash_ack;
    logic [15:0] flash_rdata;
    logic        ram_req;
    logic [23:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack;

    modport master (
        output flash_req, flash_addr,
        input  flash_ack, flash_rdata,
        output ram_req, ram_addr, ram_wdata,
        input  ram_ack
    );

    modport slave (
        input  flash_req, flash_addr,
        output flash_ack, flash_rdata,
        input  ram_req, ram_addr, ram_wdata,
        output ram_ack
    );
endinterface

// File: rtl/flash_rom_loader.sv
// Boot-time copier: moves the MEGAROM and BIOS images word by word from serial flash
// into their RAM shadows after reset, then reports DONE (or ERROR on an ACK timeout).
module flash_rom_loader #(
    parameter bit          JOB0_EN   = 1'b1,
    parameter logic [23:0] JOB0_SRC  = 24'h20_0000,
    parameter logic [23:0] JOB0_DST  = 24'h40_0000,
    parameter logic [23:0] JOB0_SIZE = 24'h20_0000,
    parameter bit          JOB1_EN   = 1'b1,
    parameter logic [23:0] JOB1_SRC  = 24'h10_0000,
    parameter logic [23:0] JOB1_DST  = 24'h70_0000,
    parameter logic [23:0] JOB1_SIZE = 24'h02_4000,
    parameter int          TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    flash_rom_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, FIN, FAULT} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       job_idx;
    logic [23:0]      src;
    logic [23:0]      dst;
    logic [23:0]      cnt;
    logic [15:0]      word_buf;
    logic [TMO_W-1:0] tmo_cnt;

    logic        job_en;
    logic [23:0] job_src;
    logic [23:0] job_dst;
    logic [23:0] job_size;
    logic        tmo_hit;

    logic load_job;
    logic next_job;
    logic raise_freq;
    logic raise_rreq;
    logic got_rdata;
    logic got_wack;
    logic go_fault;

    always_comb begin
        job_en   = JOB1_EN;
        job_src  = JOB1_SRC;
        job_dst  = JOB1_DST;
        job_size = JOB1_SIZE;
        if (job_idx == 2'd0) begin
            job_en   = JOB0_EN;
            job_src  = JOB0_SRC;
            job_dst  = JOB0_DST;
            job_size = JOB0_SIZE;
        end
    end

    // Only one request is ever outstanding, so READ and WRITE share one timer.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        load_job   = 1'b0;
        next_job   = 1'b0;
        raise_freq = 1'b0;
        raise_rreq = 1'b0;
        got_rdata  = 1'b0;
        got_wack   = 1'b0;
        go_fault   = 1'b0;
        unique case (state)
            IDLE: state_next = SETUP;
            SETUP: begin
                if (job_idx == 2'd2) begin
                    state_next = FIN;
                end else if (job_en && (job_size != 24'd0)) begin
                    load_job   = 1'b1;
                    state_next = READ;
                end else begin
                    next_job = 1'b1;
                end
            end
            READ: begin
                if (!bus.flash_req) begin
                    raise_freq = !hold;
                end else if (bus.flash_ack) begin
                    got_rdata  = 1'b1;
                    state_next = WRITE;
                end else if (tmo_hit) begin
                    go_fault   = 1'b1;
                    state_next = FAULT;
                end
            end
            WRITE: begin
                if (!bus.ram_req) begin
                    raise_rreq = !hold;
                end else if (bus.ram_ack) begin
                    got_wack = 1'b1;
                    if (cnt == 24'd2) begin
                        next_job   = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = READ;
                    end
                end else if (tmo_hit) begin
                    go_fault   = 1'b1;
                    state_next = FAULT;
                end
            end
            FIN:     state_next = FIN;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            job_idx        <= 2'd0;
            src            <= 24'd0;
            dst            <= 24'd0;
            cnt            <= 24'd0;
            word_buf       <= 16'd0;
            tmo_cnt        <= '0;
            bus.flash_req  <= 1'b0;
            bus.flash_addr <= 24'd0;
            bus.ram_req    <= 1'b0;
            bus.ram_addr   <= 24'd0;
            bus.ram_wdata  <= 16'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SETUP) || (state_next == READ) || (state_next == WRITE);
            done  <= (state_next == FIN);
            error <= (state_next == FAULT);

            if (load_job) begin
                src <= job_src;
                dst <= job_dst;
                cnt <= job_size;
            end
            if (next_job) begin
                job_idx <= job_idx + 2'd1;
            end

            if (raise_freq || raise_rreq) begin
                tmo_cnt <= '0;
            end else if ((bus.flash_req && !bus.flash_ack) || (bus.ram_req && !bus.ram_ack)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (raise_freq) begin
                bus.flash_req  <= 1'b1;
                bus.flash_addr <= src;
            end else if (got_rdata || go_fault) begin
                bus.flash_req <= 1'b0;
            end
            if (got_rdata) begin
                word_buf <= bus.flash_rdata;
            end

            if (raise_rreq) begin
                bus.ram_req   <= 1'b1;
                bus.ram_addr  <= dst;
                bus.ram_wdata <= word_buf;
            end else if (got_wack || go_fault) begin
                bus.ram_req <= 1'b0;
            end
            // Addresses wrap mod 2^24; the count cannot underflow because sizes are even.
            if (got_wack) begin
                src <= src + 24'd2;
                dst <= dst + 24'd2;
                cnt <= cnt - 24'd2;
            end
        end
    end
endmodule

// File: tb/tb_flash_rom_loader.sv
// Bench for flash_rom_loader: three differently configured copiers share one clock and
// are driven by randomized flash/RAM responders; results are compared with a job-level model.
module tb_flash_rom_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: small two-job copy; 1: job 0 disabled; 2: job 0 source wraps past 2^24.
    localparam logic [23:0] A_SRC    [2] = '{24'h20_0000, 24'h10_0000};
    localparam logic [23:0] A_DST    [2] = '{24'h40_0000, 24'h70_0000};
    localparam int          A_SIZE   [2] = '{4, 6};
    localparam logic [23:0] A_RD_SEQ [5] = '{24'h20_0000, 24'h20_0002, 24'h10_0000, 24'h10_0002, 24'h10_0004};
    localparam logic [23:0] C_RD_SEQ [4] = '{24'hFF_FFFC, 24'hFF_FFFE, 24'h00_0000, 24'h00_0002};

    logic        rst    [3];
    logic        hold   [3] = '{1'b0, 1'b0, 1'b0};
    logic        busy   [3];
    logic        done   [3];
    logic        error  [3];
    logic        fack   [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] frdata [3] = '{16'd0, 16'd0, 16'd0};
    logic        rack   [3] = '{1'b0, 1'b0, 1'b0};
    logic        freq   [3];
    logic [23:0] faddr  [3];
    logic        rreq   [3];
    logic [23:0] raddr  [3];
    logic [15:0] rwdata [3];

    logic [15:0] seed          [3];
    int          lat_max       [3];
    bit          hold_rand     [3];
    bit          withhold_en   [3];
    logic [23:0] withhold_addr [3];

    int          fwait [3];
    int          rwait [3];
    bit          fsrv  [3];
    bit          rsrv  [3];
    bit          freq_prev  [3];
    bit          rreq_prev  [3];
    logic [23:0] faddr_prev [3];
    logic [23:0] raddr_prev [3];
    logic [15:0] rwdata_prev [3];
    bit          hold_seen  [3];
    bit          rst_seen   [3];
    int          proto_viol = 0;

    logic [15:0] ram_mem [int unsigned];
    int unsigned rd_log [$];
    int unsigned wr_log [$];
    logic [23:0] sel_q [$];

    int checks = 0;
    int errors = 0;

    flash_rom_loader_if bus0();
    flash_rom_loader_if bus1();
    flash_rom_loader_if bus2();

    assign bus0.flash_ack = fack[0];  assign bus0.flash_rdata = frdata[0];  assign bus0.ram_ack = rack[0];
    assign bus1.flash_ack = fack[1];  assign bus1.flash_rdata = frdata[1];  assign bus1.ram_ack = rack[1];
    assign bus2.flash_ack = fack[2];  assign bus2.flash_rdata = frdata[2];  assign bus2.ram_ack = rack[2];
    assign freq[0] = bus0.flash_req;  assign faddr[0] = bus0.flash_addr;
    assign freq[1] = bus1.flash_req;  assign faddr[1] = bus1.flash_addr;
    assign freq[2] = bus2.flash_req;  assign faddr[2] = bus2.flash_addr;
    assign rreq[0] = bus0.ram_req;    assign raddr[0] = bus0.ram_addr;    assign rwdata[0] = bus0.ram_wdata;
    assign rreq[1] = bus1.ram_req;    assign raddr[1] = bus1.ram_addr;    assign rwdata[1] = bus1.ram_wdata;
    assign rreq[2] = bus2.ram_req;    assign raddr[2] = bus2.ram_addr;    assign rwdata[2] = bus2.ram_wdata;

    flash_rom_loader #(.JOB0_SIZE(24'd4), .JOB1_SIZE(24'd6), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(rst[0]), .hold(hold[0]), .bus(bus0.master),
        .busy(busy[0]), .done(done[0]), .error(error[0]));

    flash_rom_loader #(.JOB0_EN(1'b0), .JOB1_SIZE(24'd2)) dut_b (
        .clk(clk), .reset(rst[1]), .hold(hold[1]), .bus(bus1.master),
        .busy(busy[1]), .done(done[1]), .error(error[1]));

    flash_rom_loader #(.JOB0_SRC(24'hFF_FFFC), .JOB0_SIZE(24'd8), .JOB1_EN(1'b0)) dut_c (
        .clk(clk), .reset(rst[2]), .hold(hold[2]), .bus(bus2.master),
        .busy(busy[2]), .done(done[2]), .error(error[2]));

    // Flash contents are a fixed scramble of the address, salted per run so stale RAM never matches.
    function automatic logic [15:0] flash_word(input logic [23:0] a, input logic [15:0] s);
        logic [31:0] t;
        t = {8'h00, a} * 32'h0000_9E37;
        return t[15:0] ^ t[31:16] ^ s;
    endfunction

    function automatic int unsigned key(input int inst, input logic [23:0] a);
        return (32'(inst) << 24) | {8'h00, a};
    endfunction

    function automatic logic [15:0] ram_read(input int unsigned k);
        if (ram_mem.exists(k)) return ram_mem[k];
        return 16'hDEAD;
    endfunction

    function automatic void select_log(input int inst, input bit wr_side, input int start);
        sel_q.delete();
        if (wr_side) begin
            for (int k = start; k < wr_log.size(); k++)
                if ((wr_log[k] >> 24) == 32'(inst)) sel_q.push_back(24'(wr_log[k]));
        end else begin
            for (int k = start; k < rd_log.size(); k++)
                if ((rd_log[k] >> 24) == 32'(inst)) sel_q.push_back(24'(rd_log[k]));
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            hold_seen[i] <= hold[i];
            rst_seen[i]  <= rst[i];
        end
    end

    // Protocol watch first (what the DUT saw at the last edge), then the flash/RAM responders.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_seen[i] && !error[i]) begin
                if (freq_prev[i] && !fack[i] && (!freq[i] || faddr[i] !== faddr_prev[i])) begin
                    proto_viol++;
                    $display("[TB] inst %0d flash request changed before its ack", i);
                end
                if (rreq_prev[i] && !rack[i] &&
                    (!rreq[i] || raddr[i] !== raddr_prev[i] || rwdata[i] !== rwdata_prev[i])) begin
                    proto_viol++;
                    $display("[TB] inst %0d ram request changed before its ack", i);
                end
                if (hold_seen[i] && ((!freq_prev[i] && freq[i]) || (!rreq_prev[i] && rreq[i]))) begin
                    proto_viol++;
                    $display("[TB] inst %0d request raised while hold was high", i);
                end
            end
            freq_prev[i]   = freq[i];
            faddr_prev[i]  = faddr[i];
            rreq_prev[i]   = rreq[i];
            raddr_prev[i]  = raddr[i];
            rwdata_prev[i] = rwdata[i];

            if (fack[i]) begin
                fack[i] = 1'b0;
            end else if (!freq[i]) begin
                fsrv[i] = 1'b0;
            end else begin
                if (!fsrv[i]) begin
                    fsrv[i]  = 1'b1;
                    fwait[i] = int'($urandom_range(32'(lat_max[i]), 0));
                end
                if (withhold_en[i] && faddr[i] == withhold_addr[i]) begin
                    fsrv[i] = 1'b1;
                end else if (fwait[i] == 0) begin
                    fack[i]   = 1'b1;
                    frdata[i] = flash_word(faddr[i], seed[i]);
                    rd_log.push_back(key(i, faddr[i]));
                    fsrv[i]   = 1'b0;
                end else begin
                    fwait[i]--;
                end
            end

            if (rack[i]) begin
                rack[i] = 1'b0;
            end else if (!rreq[i]) begin
                rsrv[i] = 1'b0;
            end else begin
                if (!rsrv[i]) begin
                    rsrv[i]  = 1'b1;
                    rwait[i] = int'($urandom_range(32'(lat_max[i]), 0));
                end
                if (rwait[i] == 0) begin
                    rack[i] = 1'b1;
                    ram_mem[key(i, raddr[i])] = rwdata[i];
                    wr_log.push_back(key(i, raddr[i]));
                    rsrv[i] = 1'b0;
                end else begin
                    rwait[i]--;
                end
            end

            hold[i] = hold_rand[i] ? ($urandom_range(3, 0) == 0) : 1'b0;
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            seed[i] = 16'h0000;
            lat_max[i] = 0;
            hold_rand[i] = 1'b0;
            withhold_en[i] = 1'b0;
            withhold_addr[i] = 24'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({freq[i], rreq[i], busy[i], done[i], error[i]} !== 5'b0 ||
                faddr[i] !== 24'd0 || raddr[i] !== 24'd0 || rwdata[i] !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset_values inst %0d got req=%b/%b addr=%h/%h wdata=%h busy=%b done=%b error=%b expected all zero",
                         i, freq[i], rreq[i], faddr[i], raddr[i], rwdata[i], busy[i], done[i], error[i]);
            end
        end
    endtask

    task automatic test_small_copy();
        int rd_start;
        int done_at;
        logic busy_first;
        logic busy_at_done;
        logic [15:0] exp_w;
        logic [15:0] got_w;
        rd_start = rd_log.size();
        seed[0] = 16'($urandom);
        done_at = 0;
        busy_first = 1'b0;
        busy_at_done = 1'b1;
        @(negedge clk) rst[0] = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) busy_first = busy[0];
            if (done[0] || error[0]) begin
                done_at = n;
                busy_at_done = busy[0];
                break;
            end
        end
        checks++;
        if (busy_first !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_in_setup got %b expected 1", busy_first);
        end
        checks++;
        if (done_at != 24) begin
            errors++;
            $display("[TB] FAIL done_cycle got %0d expected 24", done_at);
        end
        checks++;
        if (busy_at_done !== 1'b0 || error[0] !== 1'b0 || done[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL small_final_flags got busy=%b error=%b done=%b expected 0/0/1", busy_at_done, error[0], done[0]);
        end
        select_log(0, 1'b0, rd_start);
        checks++;
        if (sel_q.size() != 5) begin
            errors++;
            $display("[TB] FAIL small_read_count got %0d expected 5", sel_q.size());
        end
        for (int k = 0; k < sel_q.size() && k < 5; k++) begin
            checks++;
            if (sel_q[k] !== A_RD_SEQ[k]) begin
                errors++;
                $display("[TB] FAIL small_read_order idx %0d got %h expected %h", k, sel_q[k], A_RD_SEQ[k]);
            end
        end
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < A_SIZE[j]; k += 2) begin
                exp_w = flash_word(A_SRC[j] + 24'(k), seed[0]);
                got_w = ram_read(key(0, A_DST[j] + 24'(k)));
                checks++;
                if (got_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL small_image addr %h got %h expected %h", A_DST[j] + 24'(k), got_w, exp_w);
                end
            end
    endtask

    task automatic test_skip_job0();
        int rd_start;
        int wr_start;
        int done_at;
        int low_reads;
        rd_start = rd_log.size();
        wr_start = wr_log.size();
        seed[1] = 16'($urandom);
        done_at = 0;
        @(negedge clk) rst[1] = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done[1] || error[1]) begin
                done_at = n;
                break;
            end
        end
        checks++;
        if (done_at != 8 || done[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skip_done_cycle got %0d done=%b expected 8 done=1", done_at, done[1]);
        end
        select_log(1, 1'b0, rd_start);
        low_reads = 0;
        foreach (sel_q[k]) if (sel_q[k] < 24'h10_0000) low_reads++;
        checks++;
        if (sel_q.size() != 1 || low_reads != 0 || (sel_q.size() > 0 && sel_q[0] !== 24'h10_0000)) begin
            errors++;
            $display("[TB] FAIL skip_reads got count=%0d below_0x100000=%0d expected one read at 100000", sel_q.size(), low_reads);
        end
        select_log(1, 1'b1, wr_start);
        checks++;
        if (sel_q.size() != 1 || (sel_q.size() > 0 && sel_q[0] !== 24'h70_0000)) begin
            errors++;
            $display("[TB] FAIL skip_writes got count=%0d expected one write at 700000", sel_q.size());
        end
        checks++;
        if (ram_read(key(1, 24'h70_0000)) !== flash_word(24'h10_0000, seed[1])) begin
            errors++;
            $display("[TB] FAIL skip_image got %h expected %h", ram_read(key(1, 24'h70_0000)), flash_word(24'h10_0000, seed[1]));
        end
    endtask

    task automatic test_wrap();
        int rd_start;
        int done_at;
        logic [15:0] exp_w;
        logic [15:0] got_w;
        rd_start = rd_log.size();
        seed[2] = 16'($urandom);
        done_at = 0;
        @(negedge clk) rst[2] = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done[2] || error[2]) begin
                done_at = n;
                break;
            end
        end
        checks++;
        if (done_at != 20 || done[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_done_cycle got %0d done=%b expected 20 done=1", done_at, done[2]);
        end
        select_log(2, 1'b0, rd_start);
        checks++;
        if (sel_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL wrap_read_count got %0d expected 4", sel_q.size());
        end
        for (int k = 0; k < sel_q.size() && k < 4; k++) begin
            checks++;
            if (sel_q[k] !== C_RD_SEQ[k]) begin
                errors++;
                $display("[TB] FAIL wrap_read_addr idx %0d got %h expected %h", k, sel_q[k], C_RD_SEQ[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_w = flash_word(C_RD_SEQ[k], seed[2]);
            got_w = ram_read(key(2, 24'h40_0000 + 24'(2 * k)));
            checks++;
            if (got_w !== exp_w) begin
                errors++;
                $display("[TB] FAIL wrap_image idx %0d got %h expected %h", k, got_w, exp_w);
            end
        end
    endtask

    task automatic test_random_latency_hold();
        int viol_start;
        logic [15:0] exp_w;
        logic [15:0] got_w;
        for (int it = 0; it < 3; it++) begin
            @(negedge clk) rst[0] = 1'b1;
            repeat (2) @(negedge clk);
            seed[0] = 16'($urandom);
            lat_max[0] = 5;
            hold_rand[0] = 1'b1;
            viol_start = proto_viol;
            rst[0] = 1'b0;
            for (int n = 1; n <= 3000; n++) begin
                @(posedge clk); #1;
                if (done[0] || error[0]) break;
            end
            checks++;
            if (done[0] !== 1'b1 || error[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random_completion iter %0d got done=%b error=%b expected 1/0", it, done[0], error[0]);
            end
            checks++;
            if (proto_viol != viol_start) begin
                errors++;
                $display("[TB] FAIL random_protocol iter %0d got %0d violations expected 0", it, proto_viol - viol_start);
            end
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < A_SIZE[j]; k += 2) begin
                    exp_w = flash_word(A_SRC[j] + 24'(k), seed[0]);
                    got_w = ram_read(key(0, A_DST[j] + 24'(k)));
                    checks++;
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("[TB] FAIL random_image iter %0d addr %h got %h expected %h", it, A_DST[j] + 24'(k), got_w, exp_w);
                    end
                end
        end
        hold_rand[0] = 1'b0;
        lat_max[0] = 0;
    endtask

    task automatic test_reset_mid_write();
        int rd_start;
        int wr_start;
        bit found;
        logic [15:0] exp_w;
        logic [15:0] got_w;
        @(negedge clk) rst[0] = 1'b1;
        repeat (2) @(negedge clk);
        seed[0] = 16'($urandom);
        rst[0] = 1'b0;
        found = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (rreq[0] && raddr[0] == 24'h70_0002) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL midreset_reach_job1_write got no write at 700002 expected one within 200 cycles");
        end
        rst[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (freq[0] !== 1'b0 || rreq[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_drop got freq=%b rreq=%b busy=%b expected 0/0/0", freq[0], rreq[0], busy[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        seed[0] = 16'($urandom);
        rd_start = rd_log.size();
        wr_start = wr_log.size();
        rst[0] = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done[0] || error[0]) break;
        end
        checks++;
        if (done[0] !== 1'b1 || error[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_restart_done got done=%b error=%b expected 1/0", done[0], error[0]);
        end
        select_log(0, 1'b0, rd_start);
        checks++;
        if (sel_q.size() == 0 || sel_q[0] !== 24'h20_0000) begin
            errors++;
            $display("[TB] FAIL midreset_first_read got %h (count %0d) expected 200000", sel_q.size() ? sel_q[0] : 24'hFFFFFF, sel_q.size());
        end
        select_log(0, 1'b1, wr_start);
        checks++;
        if (sel_q.size() == 0 || sel_q[0] !== 24'h40_0000) begin
            errors++;
            $display("[TB] FAIL midreset_first_write got %h (count %0d) expected 400000", sel_q.size() ? sel_q[0] : 24'hFFFFFF, sel_q.size());
        end
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < A_SIZE[j]; k += 2) begin
                exp_w = flash_word(A_SRC[j] + 24'(k), seed[0]);
                got_w = ram_read(key(0, A_DST[j] + 24'(k)));
                checks++;
                if (got_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL midreset_image addr %h got %h expected %h", A_DST[j] + 24'(k), got_w, exp_w);
                end
            end
    endtask

    task automatic test_timeout();
        int high_cnt;
        int late_reqs;
        @(negedge clk) rst[0] = 1'b1;
        repeat (2) @(negedge clk);
        seed[0] = 16'($urandom);
        withhold_en[0] = 1'b1;
        withhold_addr[0] = 24'h20_0002;
        rst[0] = 1'b0;
        high_cnt = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (freq[0] && faddr[0] == 24'h20_0002) high_cnt++;
            if (error[0] || done[0]) break;
        end
        checks++;
        if (high_cnt != 8) begin
            errors++;
            $display("[TB] FAIL timeout_req_cycles got %0d expected 8", high_cnt);
        end
        checks++;
        if (error[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0 || freq[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_flags got error=%b done=%b busy=%b freq=%b expected 1/0/0/0", error[0], done[0], busy[0], freq[0]);
        end
        late_reqs = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (freq[0] || rreq[0] || !error[0]) late_reqs++;
        end
        checks++;
        if (late_reqs != 0) begin
            errors++;
            $display("[TB] FAIL timeout_quiet got %0d cycles with requests or error cleared expected 0", late_reqs);
        end
        withhold_en[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_small_copy();
        test_skip_job0();
        test_wrap();
        test_random_latency_hold();
        test_reset_mid_write();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
